// File: rtl/udc_pkg.sv
// Shared encodings for the up/down count controller and its counter core.
package udc_pkg;

   typedef enum logic [1:0] {
      MODE_UP   = 2'b00,
      MODE_DOWN = 2'b01,
      MODE_PP   = 2'b10,
      MODE_RSVD = 2'b11
   } mode_t;

   // FINISH is the one-cycle stop a reserved-mode job makes before done pulses.
   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      RUN_UP   = 2'b01,
      RUN_DOWN = 2'b10,
      FINISH   = 2'b11
   } state_t;

endpackage

// File: rtl/updown_counter_core.sv
// W-bit up/down counter with synchronous load; terminal detection lives in the controller.
module updown_counter_core #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   input  logic         ud,
   output logic [W-1:0] count
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         count <= '0;
      else if (load)
         count <= load_val;
      else if (en)
         count <= ud ? count + 1'b1 : count - 1'b1;
   end

endmodule

// File: rtl/updown_count_ctrl.sv
// Command-driven sequencer: runs one up/down/ping-pong counting job per handshake.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | no job; cmd_ready high unless abort
// RUN_UP   | counting up toward the latched limit
// RUN_DOWN | counting down toward limit (down-once) or start (ping-pong)
// FINISH   | reserved-mode job; done pulses on the next edge
module updown_count_ctrl
   import udc_pkg::*;
#(
   parameter int W  = 4,
   parameter int PW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [1:0]    cmd_mode,
   input  logic [W-1:0]  cmd_start,
   input  logic [W-1:0]  cmd_limit,
   input  logic [PW-1:0] cmd_passes,
   input  logic          pause,
   input  logic          abort,
   output logic [W-1:0]  count,
   output logic          ud,
   output logic          busy,
   output logic          tc,
   output logic          done
);

   state_t        state, state_n;
   mode_t         mode_q, mode_n;
   logic [W-1:0]  limit_q, limit_n;
   logic [W-1:0]  start_q, start_n;
   logic [PW-1:0] pass_q, pass_n;
   logic          ud_q, ud_n;
   logic          tc_n, done_n;
   logic          load, en;
   logic [W-1:0]  target;
   logic          at_target;

   assign cmd_ready = (state == IDLE) && !abort;
   assign busy      = (state != IDLE);
   assign ud        = ud_q;

   // Only the ping-pong return leg heads back to the start value.
   assign target    = (state == RUN_DOWN && mode_q == MODE_PP) ? start_q : limit_q;
   assign at_target = (count == target);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         mode_q  <= MODE_UP;
         limit_q <= '0;
         start_q <= '0;
         pass_q  <= '0;
         ud_q    <= 1'b1;
         tc      <= 1'b0;
         done    <= 1'b0;
      end else begin
         state   <= state_n;
         mode_q  <= mode_n;
         limit_q <= limit_n;
         start_q <= start_n;
         pass_q  <= pass_n;
         ud_q    <= ud_n;
         tc      <= tc_n;
         done    <= done_n;
      end
   end

   always_comb begin
      state_n = state;
      mode_n  = mode_q;
      limit_n = limit_q;
      start_n = start_q;
      pass_n  = pass_q;
      ud_n    = ud_q;
      tc_n    = 1'b0;
      done_n  = 1'b0;
      load    = 1'b0;
      en      = 1'b0;

      case (state)
         IDLE: begin
            if (cmd_valid && cmd_ready) begin
               mode_n  = mode_t'(cmd_mode);
               limit_n = cmd_limit;
               start_n = cmd_start;
               pass_n  = (cmd_passes == '0) ? PW'(1) : cmd_passes;
               case (mode_t'(cmd_mode))
                  MODE_UP, MODE_PP: begin
                     load    = 1'b1;
                     ud_n    = 1'b1;
                     state_n = RUN_UP;
                  end
                  MODE_DOWN: begin
                     load    = 1'b1;
                     ud_n    = 1'b0;
                     state_n = RUN_DOWN;
                  end
                  default: state_n = FINISH;
               endcase
            end
         end

         RUN_UP, RUN_DOWN: begin
            if (abort) begin
               state_n = IDLE;
            end else if (!pause) begin
               if (!at_target) begin
                  en = 1'b1;
               end else begin
                  tc_n = 1'b1;
                  if (mode_q == MODE_PP && state == RUN_UP) begin
                     ud_n    = 1'b0;
                     state_n = RUN_DOWN;
                  end else if (mode_q == MODE_PP && pass_q > PW'(1)) begin
                     pass_n  = pass_q - PW'(1);
                     ud_n    = 1'b1;
                     state_n = RUN_UP;
                  end else begin
                     done_n  = 1'b1;
                     state_n = IDLE;
                  end
               end
            end
         end

         FINISH: begin
            if (abort) begin
               state_n = IDLE;
            end else if (!pause) begin
               done_n  = 1'b1;
               state_n = IDLE;
            end
         end

         default: state_n = IDLE;
      endcase
   end

   updown_counter_core #(.W(W)) u_core (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .load_val (cmd_start),
      .en       (en),
      .ud       (ud_q),
      .count    (count)
   );

endmodule

// File: tb/tb_updown_count_ctrl.sv
// Directed bench for updown_count_ctrl: per-cycle vector table plus pause/abort/reset sequences.
module tb_updown_count_ctrl;

   localparam int W  = 4;
   localparam int PW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [1:0]    cmd_mode = 2'b00;
   logic [W-1:0]  cmd_start = '0;
   logic [W-1:0]  cmd_limit = '0;
   logic [PW-1:0] cmd_passes = '0;
   logic          pause = 1'b0;
   logic          abort = 1'b0;
   logic [W-1:0]  count;
   logic          ud, busy, tc, done;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic       v;
      logic [1:0] m;
      logic [3:0] s, l, p;
      logic       pa, ab;
      logic [3:0] ec;
      logic       eud, ebusy, etc, edone, erdy;
   } vec_t;

   vec_t tbl[$];

   updown_count_ctrl #(.W(W), .PW(PW)) dut (
      .clk        (clk),
      .rst        (rst),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_mode   (cmd_mode),
      .cmd_start  (cmd_start),
      .cmd_limit  (cmd_limit),
      .cmd_passes (cmd_passes),
      .pause      (pause),
      .abort      (abort),
      .count      (count),
      .ud         (ud),
      .busy       (busy),
      .tc         (tc),
      .done       (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic void add(input logic v, input logic [1:0] m, input logic [3:0] s,
                               input logic [3:0] l, input logic [3:0] p,
                               input logic pa, input logic ab, input logic [3:0] ec,
                               input logic eud, input logic ebusy, input logic etc,
                               input logic edone, input logic erdy);
      vec_t r;
      r.v = v; r.m = m; r.s = s; r.l = l; r.p = p; r.pa = pa; r.ab = ab;
      r.ec = ec; r.eud = eud; r.ebusy = ebusy; r.etc = etc; r.edone = edone; r.erdy = erdy;
      tbl.push_back(r);
   endfunction

   function automatic void run_row(input logic [3:0] ec, input logic eud, input logic etc);
      add(0, 0, 0, 0, 0, 0, 0, ec, eud, 1, etc, 0, 0);
   endfunction

   initial begin
      int n;

      // up-once 3 -> 6
      add(1, 2'd0, 3, 6, 0, 0, 0, 3, 1, 1, 0, 0, 0);
      run_row(4, 1, 0); run_row(5, 1, 0); run_row(6, 1, 0);
      add(0, 0, 0, 0, 0, 0, 0, 6, 1, 0, 1, 1, 1);
      // down-once 2 -> 14 through the wrap
      add(1, 2'd1, 2, 14, 0, 0, 0, 2, 0, 1, 0, 0, 0);
      run_row(1, 0, 0); run_row(0, 0, 0); run_row(15, 0, 0); run_row(14, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 14, 0, 0, 1, 1, 1);
      // ping-pong 1 <-> 3, two passes
      add(1, 2'd2, 1, 3, 2, 0, 0, 1, 1, 1, 0, 0, 0);
      run_row(2, 1, 0); run_row(3, 1, 0); run_row(3, 0, 1); run_row(2, 0, 0);
      run_row(1, 0, 0); run_row(1, 1, 1); run_row(2, 1, 0); run_row(3, 1, 0);
      run_row(3, 0, 1); run_row(2, 0, 0); run_row(1, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 1);
      // ping-pong with passes=0 behaves as one pass
      add(1, 2'd2, 5, 6, 0, 0, 0, 5, 1, 1, 0, 0, 0);
      run_row(6, 1, 0); run_row(6, 0, 1); run_row(5, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 5, 0, 0, 1, 1, 1);
      // reserved mode: count and ud untouched, done only
      add(1, 2'd3, 9, 2, 0, 0, 0, 5, 0, 1, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 5, 0, 0, 0, 1, 1);
      // abort in IDLE blocks acceptance
      add(1, 2'd0, 3, 3, 0, 0, 1, 5, 0, 0, 0, 0, 0);
      // start == limit: done one cycle after accept
      add(1, 2'd0, 7, 7, 0, 0, 0, 7, 1, 1, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 7, 1, 0, 1, 1, 1);

      rst = 1'b0;
      #12;
      chk("reset count", count, 0);
      chk("reset ud", ud, 1);
      chk("reset busy", busy, 0);
      chk("reset tc", tc, 0);
      chk("reset done", done, 0);
      chk("reset ready", cmd_ready, 1);
      #1 rst = 1'b1;

      foreach (tbl[i]) begin
         cmd_valid  = tbl[i].v;
         cmd_mode   = tbl[i].m;
         cmd_start  = tbl[i].s;
         cmd_limit  = tbl[i].l;
         cmd_passes = tbl[i].p;
         pause      = tbl[i].pa;
         abort      = tbl[i].ab;
         tick();
         chk($sformatf("row%0d count", i), count, tbl[i].ec);
         chk($sformatf("row%0d ud", i), ud, tbl[i].eud);
         chk($sformatf("row%0d busy", i), busy, tbl[i].ebusy);
         chk($sformatf("row%0d tc", i), tc, tbl[i].etc);
         chk($sformatf("row%0d done", i), done, tbl[i].edone);
         chk($sformatf("row%0d ready", i), cmd_ready, tbl[i].erdy);
      end
      cmd_valid = 1'b0;
      abort     = 1'b0;
      pause     = 1'b0;

      // pause for 3 cycles at count 4 during up-once 0 -> 9
      cmd_valid = 1'b1; cmd_mode = 2'd0; cmd_start = 0; cmd_limit = 9;
      tick();
      cmd_valid = 1'b0;
      chk("pause accept count", count, 0);
      repeat (4) tick();
      chk("pause pre count", count, 4);
      pause = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk($sformatf("pause hold%0d count", k), count, 4);
         chk($sformatf("pause hold%0d tc", k), tc, 0);
         chk($sformatf("pause hold%0d busy", k), busy, 1);
      end
      pause = 1'b0;
      n = 7;
      while (!done && n < 40) begin
         tick();
         n++;
      end
      chk("pause job length", n, 13);
      chk("pause end count", count, 9);
      chk("pause end tc", tc, 1);

      // abort at count 5, then a fresh command right after
      tick();
      cmd_valid = 1'b1; cmd_mode = 2'd0; cmd_start = 0; cmd_limit = 9;
      tick();
      cmd_valid = 1'b0;
      repeat (5) tick();
      chk("abort pre count", count, 5);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort busy", busy, 0);
      chk("abort count", count, 5);
      chk("abort done", done, 0);
      chk("abort tc", tc, 0);
      cmd_valid = 1'b1; cmd_mode = 2'd0; cmd_start = 1; cmd_limit = 2;
      #1 chk("post-abort ready", cmd_ready, 1);
      tick();
      cmd_valid = 1'b0;
      chk("post-abort busy", busy, 1);
      chk("post-abort count", count, 1);
      tick();
      tick();
      chk("post-abort done", done, 1);
      chk("post-abort end count", count, 2);

      // async reset in the middle of a ping-pong job
      tick();
      cmd_valid = 1'b1; cmd_mode = 2'd2; cmd_start = 1; cmd_limit = 3; cmd_passes = 2;
      tick();
      cmd_valid = 1'b0;
      repeat (4) tick();
      chk("pp pre-reset count", count, 2);
      chk("pp pre-reset ud", ud, 0);
      #3 rst = 1'b0;
      #1;
      chk("async reset count", count, 0);
      chk("async reset ud", ud, 1);
      chk("async reset busy", busy, 0);
      #2 rst = 1'b1;
      abort = 1'b1;
      cmd_valid = 1'b1; cmd_mode = 2'd0; cmd_start = 3; cmd_limit = 6;
      #1 chk("abort blocks ready", cmd_ready, 0);
      tick();
      chk("abort blocks busy", busy, 0);
      chk("abort blocks count", count, 0);
      cmd_valid = 1'b0;
      abort = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/updown_count_ctrl.md
Name: updown_count_ctrl

Overview:
Command-driven sequencer wrapping a W-bit synchronous up/down counter. Accepts one counting job per valid/ready handshake: start value, limit, mode, pass count. Sequences direction, terminal detection and completion signalling so higher-level blocks (timers, PWM, test drivers) need not toggle the ud line cycle by cycle. One controller FSM drives one counter core.

Parameters:
W, 4, counter and start/limit width
PW, 4, width of ping-pong pass count

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
cmd_valid  in  1  command present
cmd_ready  out  1  controller can accept a command
cmd_mode  in  2  00 up-once, 01 down-once, 10 ping-pong, 11 reserved
cmd_start  in  W  value loaded on accept
cmd_limit  in  W  terminal value
cmd_passes  in  PW  ping-pong passes (0 treated as 1)
pause  in  1  hold count and state while 1
abort  in  1  cancel current job
count  out  W  counter value
ud  out  1  current direction, 1 = up
busy  out  1  job in progress
tc  out  1  one-cycle pulse at each terminal/reversal point
done  out  1  one-cycle pulse on normal job completion

Behaviour:
- Reset (rst=0, async): state IDLE, count=0, ud=1, busy=0, tc=0, done=0. Deassertion takes effect at the next clk edge.
- cmd_ready = (state==IDLE) && !abort. This is combinational.
- Accept: the edge where cmd_valid && cmd_ready. After that edge:
  - count=cmd_start, busy=1.
  - ud=1 for modes 00 and 10; ud=0 for mode 01.
  - cmd_limit and cmd_passes are latched.
  - state: RUN_UP (00, 10) or RUN_DOWN (01).
- RUN edge with pause=0 and abort=0:
  - If count==limit: terminal event, tc=1 for one cycle.
  - Otherwise: count=count±1, modulo 2^W. Wrap is legal, e.g. up from 14 to limit 2 passes through 15, 0, 1, 2.
- Terminal event, once-modes: state IDLE, done=1 for one cycle, busy=0, count holds.
- Ping-pong:
  - Terminal in RUN_UP: ud=0, state RUN_DOWN, target becomes the latched start.
  - Terminal in RUN_DOWN completes one pass. If passes remain, go to RUN_UP with target limit. Otherwise finish as a once-mode job.
  - The reversal edge does not move count.
- start==limit: terminal on the first RUN edge. Up-once therefore gives done one cycle after accept.
- Mode 11: accepted, count and ud unchanged, done pulses one cycle after accept, tc stays 0.
- pause=1: count, ud, state and the pass counter hold. tc and done stay 0.
- abort=1 in RUN: the next edge forces IDLE, busy=0, count holds, no tc/done. abort overrides pause and terminal. abort in IDLE is a no-op and blocks acceptance.
- Reset mid-job: immediate return to reset values. The job is discarded.
- tc and done are registered, never asserted together except on the final terminal edge of a job, where both pulse.

Decomposition:
- Package udc_pkg: mode encodings (MODE_UP, MODE_DOWN, MODE_PP, MODE_RSVD) and state encoding (IDLE, RUN_UP, RUN_DOWN).
- Sub-module updown_counter_core: W-bit register with load, load value, enable, ud and async active-low reset. It has no terminal logic.
- The controller owns the FSM, the latched limit/start, the pass counter, and generation of tc/done.

Test Plan:
- Reset then up-once, start=3, limit=6 -> count 3,4,5,6 on successive edges. tc and done pulse together one cycle after count reaches 6. busy falls with done. cmd_ready returns to 1.
- Down-once, start=2, limit=14 -> count 2,1,0,15,14, then tc and done. Checks wrap-around.
- Ping-pong, start=1, limit=3, passes=2 -> count 1,2,3,3,2,1,1,2,3,3,2,1. tc at each reversal and at the end. done once at the end. ud toggles at the reversals.
- Up-once 0 -> 9 with pause high for 3 cycles at count=4 -> count holds at 4 for exactly 3 cycles. Total job length grows by 3.
- abort at count=5 during up-once 0 -> 9 -> busy=0 next edge, count stays 5, no done. A new command is accepted on the following cycle.
- rst pulled low mid ping-pong -> count=0, ud=1, busy=0 immediately without a clock. A cmd_valid held high while abort=1 is not accepted.
